ceyloniac_memory_arbiter: RTL and testbench

- Shares the single memory port of the CEYLONIAC multi-cycle processor between two requesters: the multi-cycle control unit (fetch, LOAD, STORE) and a host/DMA loader.
- Stalls the control unit through its control_enable input until the CPU's access completes.
- Sits between the control unit/datapath and the memory.
- Fixed memory latency; one outstanding access; round-robin arbitration.

---
 rtl/ceyloniac_memory_arbiter.sv | 135 +++++++++++++
 tb/tb_ceyloniac_memory_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ceyloniac_memory_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the CEYLONIAC control unit and a host loader.
// Optional host ownership locking is enabled by defining CEYLONIAC_ARB_HOST_LOCK_EN.
module ceyloniac_memory_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 2,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_mem_read,
  input  logic                  cpu_mem_write,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  control_enable,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_done,
  input  logic                  host_lock,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state;
  logic       last_grant;
  logic [3:0] cnt;
  logic       cpu_req;
  logic       grant_valid;
  logic       grant_host;

  assign cpu_req        = cpu_mem_read | cpu_mem_write;
  assign control_enable = ~cpu_req | (state == DONE && owner == 1'b0);

`ifdef CEYLONIAC_ARB_HOST_LOCK_EN
  localparam int LW = $clog2(MAX_LOCK + 1);
  logic          lock_active;
  logic [LW-1:0] lock_cnt;
`else
  logic unused_host_lock;
  assign unused_host_lock = host_lock ^ (MAX_LOCK == 0);
`endif

  always_comb begin
    grant_valid = cpu_req | host_req;
    if (cpu_req && host_req) grant_host = ~last_grant;
    else                     grant_host = host_req;
`ifdef CEYLONIAC_ARB_HOST_LOCK_EN
    // A locked host jumps the round-robin until the lock budget is spent.
    if (lock_active && host_req && lock_cnt < LW'(MAX_LOCK)) grant_host = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
      host_done  <= 1'b0;
      owner      <= 1'b0;
`ifdef CEYLONIAC_ARB_HOST_LOCK_EN
      lock_active <= 1'b0;
      lock_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          host_done <= 1'b0;
          if (grant_valid) begin
            owner      <= grant_host;
            last_grant <= grant_host;
            cnt        <= '0;
            state      <= ACCESS;
            if (grant_host) begin
              mem_addr  <= host_addr;
              mem_wdata <= host_wdata;
              mem_write <= host_we;
              mem_read  <= ~host_we;
            end else begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_write <= cpu_mem_write;
              mem_read  <= ~cpu_mem_write;
            end
`ifdef CEYLONIAC_ARB_HOST_LOCK_EN
            if (!grant_host)    lock_cnt <= '0;
            else if (host_lock) lock_cnt <= lock_cnt + 1'b1;
`endif
          end
        end
        ACCESS: begin
          if (cnt == 4'(MEM_LAT - 1)) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_read) begin
              if (owner) host_rdata <= mem_rdata;
              else       cpu_rdata  <= mem_rdata;
            end
            host_done <= owner;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          host_done <= 1'b0;
          state     <= IDLE;
`ifdef CEYLONIAC_ARB_HOST_LOCK_EN
          lock_active <= owner & host_lock;
`endif
        end
        default: state <= IDLE;
      endcase
`ifdef CEYLONIAC_ARB_HOST_LOCK_EN
      if (!host_lock) lock_cnt <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_ceyloniac_memory_arbiter.sv
// Self-checking bench for ceyloniac_memory_arbiter: directed cases plus randomized traffic
// compared against a transaction-level round-robin model.
module tb_ceyloniac_memory_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mem_read, cpu_mem_write;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        control_enable;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata, host_rdata;
  logic        host_done, host_lock;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        owner;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model state
  logic        m_last;
  logic [31:0] exp_cpu_rd, exp_host_rd;

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {a ^ 16'hC3A5, ~a};
  endfunction

  assign mem_rdata = memfn(mem_addr);

  ceyloniac_memory_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_LAT(MEM_LAT), .MAX_LOCK(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .control_enable(control_enable),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_done(host_done),
    .host_lock(host_lock),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #1;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_host_done", host_done, 0);
    chk("rst_owner", owner, 0);
    chk("rst_ce", control_enable, 1);
    step;
    reset = 1'b0;
    m_last = 1'b1;
    exp_cpu_rd = '0;
    exp_host_rd = '0;
  endtask

  // Called in an IDLE cycle with requests already applied; leaves the bench in the next IDLE cycle.
  task automatic run_slot(input logic scramble);
    logic        creq, hst, we;
    logic [15:0] a;
    logic [31:0] d;
    creq = cpu_mem_read | cpu_mem_write;
    if (!creq && !host_req) begin
      chk("idle_ce", control_enable, 1);
      step;
      chk("idle_rd", mem_read, 0);
      chk("idle_wr", mem_write, 0);
      return;
    end
    hst = (creq && host_req) ? ~m_last : host_req;
    we  = hst ? host_we : cpu_mem_write;
    a   = hst ? host_addr : cpu_addr;
    d   = hst ? host_wdata : cpu_wdata;
    chk("req_ce", control_enable, !creq);
    for (int unsigned i = 0; i < MEM_LAT; i++) begin
      step;
      if (scramble && i == 0) begin
        cpu_addr = 16'($urandom); cpu_wdata = $urandom;
        host_addr = 16'($urandom); host_wdata = $urandom;
        if (hst) host_req = 1'($urandom);
        #1;
      end
      chk("acc_rd", mem_read, !we);
      chk("acc_wr", mem_write, we);
      chk("acc_addr", mem_addr, a);
      chk("acc_wdata", mem_wdata, d);
      chk("acc_owner", owner, hst);
      chk("acc_hdone", host_done, 0);
      chk("acc_ce", control_enable, !creq);
    end
    step;
    if (!we) begin
      if (hst) exp_host_rd = memfn(a);
      else     exp_cpu_rd  = memfn(a);
    end
    chk("done_rd", mem_read, 0);
    chk("done_wr", mem_write, 0);
    chk("done_hdone", host_done, hst);
    chk("done_ce", control_enable, !creq | !hst);
    chk("done_owner", owner, hst);
    chk("done_cpu_rdata", cpu_rdata, exp_cpu_rd);
    chk("done_host_rdata", host_rdata, exp_host_rd);
    m_last = hst;
    step;
    chk("post_hdone", host_done, 0);
  endtask

  initial begin
    reset = 1'b1; host_lock = 1'b0;
    idle_inputs;
    cpu_addr = '0; cpu_wdata = '0; host_addr = '0; host_wdata = '0;
    step; step;
    do_reset;

    // CPU read of 0x0010
    cpu_mem_read = 1'b1; cpu_addr = 16'h0010; #1;
    run_slot(1'b0);
    chk("cpu_read_val", cpu_rdata, 32'hDEADBEEF);
    idle_inputs; #1;

    // Host write with CPU idle
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0100; host_wdata = 32'h12345678; #1;
    run_slot(1'b0);
    idle_inputs; #1;

    // Simultaneous CPU read and host write right after reset: CPU first, then host
    do_reset;
    cpu_mem_read = 1'b1; cpu_addr = 16'h0020;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0200; host_wdata = 32'hCAFEF00D; #1;
    run_slot(1'b0);
    run_slot(1'b0);
    chk("sim_last_host", m_last, 1);

    // Continuous requests from both: grants alternate
    for (int k = 0; k < 6; k++) begin
      host_we = 1'($urandom); cpu_mem_write = 1'($urandom);
      cpu_addr = 16'($urandom); host_addr = 16'($urandom);
      cpu_wdata = $urandom; host_wdata = $urandom;
      cpu_mem_read = ~cpu_mem_write; host_req = 1'b1; #1;
      run_slot(1'b0);
    end
    idle_inputs; #1;

    // Randomized traffic, including both CPU strobes high and late input changes
    for (int k = 0; k < 40; k++) begin
      cpu_mem_read = 1'($urandom); cpu_mem_write = 1'($urandom);
      host_req = 1'($urandom); host_we = 1'($urandom);
      cpu_addr = 16'($urandom); host_addr = 16'($urandom);
      cpu_wdata = $urandom; host_wdata = $urandom; #1;
      run_slot(1'($urandom));
    end
    idle_inputs; #1;

    // Ensure host_rdata is nonzero, then reset in the second ACCESS cycle of a host read
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0333; #1;
    run_slot(1'b0);
    chk("pre_rst_hrd", host_rdata, memfn(16'h0333));
    host_addr = 16'h0444; #1;
    step;
    step;
    chk("abort_pre_rd", mem_read, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_rd", mem_read, 0);
    chk("abort_hrd", host_rdata, 0);
    chk("abort_hdone", host_done, 0);
    host_req = 1'b0;
    step;
    chk("abort_hdone2", host_done, 0);
    reset = 1'b0;
    step;
    chk("abort_hdone3", host_done, 0);
    chk("abort_hrd2", host_rdata, 0);
    chk("abort_idle_rd", mem_read, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
